// File: rtl/gate_exerciser.sv
// gate_exerciser: drives all four a/b vectors into a 2-input gate, samples c after a settle
// time and reports a per-vector mismatch mask against a latched truth table.
module gate_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] truth,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);
    localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);
    logic [1:0] state;
    logic [CNT_W-1:0] cnt;
    logic [3:0] truth_q;
    logic [3:0] mask_next;
    // a/b are the registered vector index itself, so they change only on clock edges
    assign {a, b} = vec_idx;
    assign mask_next = fail_mask | (4'(c != truth_q[vec_idx]) << vec_idx);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            truth_q   <= '0;
            vec_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    truth_q   <= truth;
                    fail_mask <= '0;
                    pass      <= 1'b0;
                    vec_idx   <= '0;
                    busy      <= 1'b1;
                    cnt       <= '0;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= SAMPLE;
                end
                SAMPLE: begin
                    fail_mask <= mask_next;
                    if (vec_idx != 2'd3) begin
                        vec_idx <= vec_idx + 2'd1;
                        cnt     <= '0;
                        state   <= SETTLE;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (mask_next == 4'd0);
                        vec_idx <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
